yx_route_engine: RTL

YX_ROUTE_ENGINE -- requirements
Module: yx_route_engine

---
 rtl/yx_route_engine.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/yx_route_engine.sv
// -----------------------------------------------------------------------------
// yx_route_engine
//
// Dimension-ordered route computation for one router input port. The head flit
// of each packet carries the destination address, which selects an output
// direction. That direction stays locked for the rest of the packet. Flits pass
// through a single output register that uses valid/ready flow control.
//
// Parameters
//   COORD_W  width of each X / Y coordinate field
//   FLIT_W   flit width (>= 2*COORD_W)
//   MODE     0 = YX order (Y resolved first), 1 = XY order (X resolved first)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   router_addr_i  local address, {X, Y}, static during operation
//   in_valid_i     upstream flit valid
//   in_ready_o     engine accepts a flit this cycle
//   in_flit_i      flit; on a head flit, [2*COORD_W-1:0] holds the destination {X, Y}
//   in_head_i      head marker
//   in_tail_i      tail marker (head & tail = single-flit packet)
//   out_valid_o    output flit valid
//   out_ready_i    downstream accepts the output flit
//   out_flit_o     registered flit
//   out_tail_o     registered tail marker
//   out_dir_o      output port: 000 N, 001 S, 010 W, 011 E, 100 local
//   busy_o         a multi-flit packet route is locked
//   err_o          (only with YX_ROUTE_ERR_EN) one-cycle pulse after a
//                  non-head in IDLE or a head in PACKET was accepted
//
// Optional feature macro: YX_ROUTE_ERR_EN
// -----------------------------------------------------------------------------
module yx_route_engine #(
   parameter int COORD_W = 4,
   parameter int FLIT_W  = 32,
   parameter int MODE    = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [2*COORD_W-1:0] router_addr_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [FLIT_W-1:0]    in_flit_i,
   input  logic                 in_head_i,
   input  logic                 in_tail_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [FLIT_W-1:0]    out_flit_o,
   output logic                 out_tail_o,
   output logic [2:0]           out_dir_o,
   output logic                 busy_o
`ifdef YX_ROUTE_ERR_EN
   ,
   output logic                 err_o
`endif
);

   typedef enum logic {
      IDLE,
      PACKET
   } state_t;

   typedef enum logic [2:0] {
      DIR_N = 3'b000,
      DIR_S = 3'b001,
      DIR_W = 3'b010,
      DIR_E = 3'b011,
      DIR_L = 3'b100
   } dir_t;

   state_t state_q, state_d;
   dir_t   dir_q, dir_d;
   dir_t   route_dir;
   dir_t   emit_dir;
   logic   emit;
   logic   xfer_in;
   logic   xfer_out;
`ifdef YX_ROUTE_ERR_EN
   logic   err_d;
`endif

   logic [COORD_W-1:0] dx, dy, rx, ry;

   assign dx = in_flit_i[2*COORD_W-1:COORD_W];
   assign dy = in_flit_i[COORD_W-1:0];
   assign rx = router_addr_i[2*COORD_W-1:COORD_W];
   assign ry = router_addr_i[COORD_W-1:0];

   // A new flit can enter when the output register is empty or is being
   // drained in this same cycle.
   assign in_ready_o = !out_valid_o | out_ready_i;
   assign xfer_in    = in_valid_i & in_ready_o;
   assign xfer_out   = out_valid_o & out_ready_i;
   assign busy_o     = (state_q == PACKET);

   // Route computation from the destination field of the incoming flit.
   // East is the direction of decreasing X and west of increasing X.
   always_comb begin
      dir_t y_dir;
      dir_t x_dir;
      y_dir = (dy > ry) ? DIR_N : DIR_S;
      x_dir = (dx < rx) ? DIR_E : DIR_W;
      if ((dx == rx) && (dy == ry))
         route_dir = DIR_L;
      else if (MODE == 0)
         route_dir = (dy != ry) ? y_dir : x_dir;
      else
         route_dir = (dx != rx) ? x_dir : y_dir;
   end

   // Next-state and emit decode.
   // NOTE: every signal gets a default first so that no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d  = state_q;
      dir_d    = dir_q;
      emit     = 1'b0;
      emit_dir = dir_q;
`ifdef YX_ROUTE_ERR_EN
      err_d    = 1'b0;
`endif
      if (xfer_in) begin
         case (state_q)
            IDLE: begin
               if (in_head_i) begin
                  dir_d    = route_dir;
                  emit     = 1'b1;
                  emit_dir = route_dir;
                  if (!in_tail_i)
                     state_d = PACKET;
               end else begin
                  // Stray body/tail flit with no route: drop it.
`ifdef YX_ROUTE_ERR_EN
                  err_d = 1'b1;
`endif
               end
            end
            PACKET: begin
               // A head inside a packet is forwarded as a body flit on the
               // locked route. It is not re-routed.
               emit = 1'b1;
               if (in_tail_i)
                  state_d = IDLE;
`ifdef YX_ROUTE_ERR_EN
               if (in_head_i)
                  err_d = 1'b1;
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
   // NOTE: all control and datapath registers reset; there is no memory array here to exempt.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         dir_q       <= DIR_N;
         out_valid_o <= 1'b0;
         out_flit_o  <= '0;
         out_tail_o  <= 1'b0;
         out_dir_o   <= DIR_N;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         if (emit) begin
            out_valid_o <= 1'b1;
            out_flit_o  <= in_flit_i;
            out_tail_o  <= in_tail_i;
            out_dir_o   <= emit_dir;
         end else if (xfer_out) begin
            out_valid_o <= 1'b0;
         end
      end
   end

`ifdef YX_ROUTE_ERR_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         err_o <= 1'b0;
      else
         err_o <= err_d;
   end
`endif

endmodule
